// File: rtl/calc_bin2bcd_if.sv
// Handshake/data bundle between the calculator (master) and the
// binary-to-BCD converter (slave).
interface calc_bin2bcd_if #(
  parameter int BITS   = 32,
  parameter int DIGITS = 10
);
  logic [BITS-1:0]     bin_in;
  logic                convert;
  logic                busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                overflow;
  logic                neg;

  modport master (
    output bin_in, convert,
    input  busy, bcd_out, bcd_valid, overflow, neg
  );

  modport slave (
    input  bin_in, convert,
    output busy, bcd_out, bcd_valid, overflow, neg
  );
endinterface

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: sequential double-dabble binary-to-BCD converter, one shift
// per clock. Optional feature macro: BIN2BCD_SIGNED_EN (two's complement
// input, magnitude converted and sign reported on neg).
module calc_bin2bcd #(
  parameter int BITS   = 32,
  parameter int DIGITS = 10
) (
  input  logic          clk,
  input  logic          reset,
  calc_bin2bcd_if.slave bus
);

  localparam int CW = $clog2(BITS + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BITS-1:0] r_shreg;
  logic [SW-1:0]   r_scratch;
  logic [SW-1:0]   w_corr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_sign;
  logic [SW-1:0]   r_bcd;
  logic            r_valid;
  logic            r_overflow;
  logic            r_neg;
  logic            w_busy;
  logic [BITS-1:0] w_mag;
  logic            w_sign;

`ifdef BIN2BCD_SIGNED_EN
  // Negation is done as BITS-bit unsigned so the most negative value maps to 2^(BITS-1).
  assign w_sign = bus.bin_in[BITS-1];
  assign w_mag  = w_sign ? (BITS'(0) - bus.bin_in) : bus.bin_in;
`else
  assign w_sign = 1'b0;
  assign w_mag  = bus.bin_in;
`endif

  // Add-3 correction per digit on the pre-shift scratch; a digit <=9 never carries out.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
      assign w_corr[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                 (r_scratch[4*gi +: 4] + 4'd3) :
                                 r_scratch[4*gi +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: convert only honoured in IDLE; last shift when counter reaches 1.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.convert) w_state_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers SHIFT and DONE so it drops together with the valid pulse.
  always_comb begin
    w_busy = 1'b0;
    if (r_state != S_IDLE) w_busy = 1'b1;
  end

  // Datapath: latch, shift with correction, and publish the result at DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_sign     <= 1'b0;
      r_bcd      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.convert) begin
            r_shreg   <= w_mag;
            r_sign    <= w_sign;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CW'(BITS);
          end
        end
        S_SHIFT: begin
          {r_scratch, r_shreg} <= {w_corr[SW-2:0], r_shreg, 1'b0};
          if (w_corr[SW-1]) r_ovf <= 1'b1;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_bcd      <= r_scratch;
          r_overflow <= r_ovf;
          r_neg      <= r_sign;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.bcd_out   = r_bcd;
  assign bus.bcd_valid = r_valid;
  assign bus.overflow  = r_overflow;
  assign bus.neg       = r_neg;

endmodule

// File: tb/tb_calc_bin2bcd.sv
// Scoreboard bench for calc_bin2bcd: a 32-bit/10-digit instance and an
// 8-bit/2-digit instance for the overflow boundary.
module tb_calc_bin2bcd;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_bin2bcd_if #(.BITS(32), .DIGITS(10)) bus32 ();
  calc_bin2bcd_if #(.BITS(8),  .DIGITS(2))  bus8 ();

  calc_bin2bcd #(.BITS(32), .DIGITS(10)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  calc_bin2bcd #(.BITS(8),  .DIGITS(2))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (bus32.bcd_valid === 1'b1) begin
      check("valid32_expected", {63'b0, q32.size() != 0}, 64'd1);
      if (q32.size() != 0) begin
        exp_t e;
        e = q32.pop_front();
        $display("txn32 cyc=%0d bcd=%h ovf=%b neg=%b", cyc, bus32.bcd_out, bus32.overflow, bus32.neg);
        check("bcd32",     {24'b0, bus32.bcd_out}, {24'b0, e.bcd});
        check("ovf32",     {63'b0, bus32.overflow}, {63'b0, e.ovf});
        check("neg32",     {63'b0, bus32.neg}, {63'b0, e.neg});
        check("latency32", 64'(cyc), 64'(e.cyc));
        check("busy32_low_with_valid", {63'b0, bus32.busy}, 64'd0);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (bus8.bcd_valid === 1'b1) begin
      check("valid8_expected", {63'b0, q8.size() != 0}, 64'd1);
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        $display("txn8 cyc=%0d bcd=%h ovf=%b neg=%b", cyc, bus8.bcd_out, bus8.overflow, bus8.neg);
        check("bcd8",     {56'b0, bus8.bcd_out}, {24'b0, e.bcd});
        check("ovf8",     {63'b0, bus8.overflow}, {63'b0, e.ovf});
        check("latency8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
    check("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    check("drain8", 64'(q8.size()), 64'd0);
  endtask

  task automatic conv32(input logic [31:0] v, input logic [39:0] bcd, input logic ovf, input logic neg);
    exp_t e;
    @(negedge clk);
    bus32.bin_in  = v;
    bus32.convert = 1'b1;
    e.bcd = bcd; e.ovf = ovf; e.neg = neg; e.cyc = cyc + 1 + 32 + 1;
    q32.push_back(e);
    @(negedge clk);
    bus32.convert = 1'b0;
    drain32();
  endtask

  task automatic conv8(input logic [7:0] v, input logic [7:0] bcd, input logic ovf);
    exp_t e;
    @(negedge clk);
    bus8.bin_in  = v;
    bus8.convert = 1'b1;
    e.bcd = {32'b0, bcd}; e.ovf = ovf; e.neg = 1'b0; e.cyc = cyc + 1 + 8 + 1;
    q8.push_back(e);
    @(negedge clk);
    bus8.convert = 1'b0;
    drain8();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c0;
    reset = 1'b1;
    bus32.bin_in = '0; bus32.convert = 1'b0;
    bus8.bin_in  = '0; bus8.convert  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd32",   {24'b0, bus32.bcd_out}, 64'd0);
    check("rst_valid32", {63'b0, bus32.bcd_valid}, 64'd0);
    check("rst_busy32",  {63'b0, bus32.busy}, 64'd0);
    check("rst_ovf32",   {63'b0, bus32.overflow}, 64'd0);
    check("rst_neg32",   {63'b0, bus32.neg}, 64'd0);
    check("rst_busy8",   {63'b0, bus8.busy}, 64'd0);
    reset = 1'b0;

    // Zero, then a plain value.
    conv32(32'd0, 40'h00_0000_0000, 1'b0, 1'b0);
    conv32(32'd12345, 40'h00_0001_2345, 1'b0, 1'b0);

    // Extremes of the input range.
`ifdef BIN2BCD_SIGNED_EN
    conv32(32'hFFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b1);
    conv32(32'h8000_0000, 40'h21_4748_3648, 1'b0, 1'b1);
`else
    conv32(32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, 1'b0);
    conv32(32'h8000_0000, 40'h21_4748_3648, 1'b0, 1'b0);
`endif

    // convert held for 40 cycles: accepted at k and k+34 only; mid-run bin_in change ignored.
    @(negedge clk);
    bus32.bin_in  = 32'd999;
    bus32.convert = 1'b1;
    c0 = cyc;
    e.bcd = 40'h00_0000_0999; e.ovf = 1'b0; e.neg = 1'b0;
    e.cyc = c0 + 1 + 33;      q32.push_back(e);
    e.cyc = c0 + 1 + 34 + 33; q32.push_back(e);
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (i == 5)  bus32.bin_in = 32'd1234;
      if (i == 20) bus32.bin_in = 32'd999;
    end
    bus32.convert = 1'b0;
    drain32();
    repeat (40) @(negedge clk);

    // Reset 10 cycles into a conversion: aborted, no valid pulse.
    @(negedge clk);
    bus32.bin_in  = 32'd5000;
    bus32.convert = 1'b1;
    @(negedge clk);
    bus32.convert = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_bcd32",  {24'b0, bus32.bcd_out}, 64'd0);
    check("abort_busy32", {63'b0, bus32.busy}, 64'd0);
    check("abort_ovf32",  {63'b0, bus32.overflow}, 64'd0);
    repeat (40) @(negedge clk);
    conv32(32'd7, 40'h00_0000_0007, 1'b0, 1'b0);

    // Two-digit overflow boundary.
    conv8(8'd100, 8'h00, 1'b1);
    conv8(8'd99,  8'h99, 1'b0);
    conv8(8'd255, 8'h55, 1'b0 | 1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
